// File: rtl/onehot_mux_pkg.sv
// onehot_mux_pkg
//   Shared constants and helpers for the one-hot AND-OR multiplexer.
//   - ONEHOT_MUX_DEF_N_INPUTS / ONEHOT_MUX_DEF_W_INPUT : default parameter values.
//   - onehot_mux_tree_depth(n) : ceil(log2(n)), depth of the balanced reduction
//     trees (0 for n = 1).
package onehot_mux_pkg;

  localparam int ONEHOT_MUX_DEF_N_INPUTS = 2;
  localparam int ONEHOT_MUX_DEF_W_INPUT  = 32;

  function automatic int onehot_mux_tree_depth(input int n);
    int d;
    d = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << d) < n) d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/onehot_mux_sel_check.sv
// onehot_mux_sel_check
//   Select-integrity monitor for the one-hot mux.
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset (sticky flag only)
//     sel        : N_INPUTS-bit select vector under observation
//     sel_none   : combinational, 1 when sel is all zero
//     sel_multi  : combinational, 1 when two or more sel bits are set
//     sel_err    : registered sticky flag, set after any cycle with sel_multi=1,
//                  cleared only by reset
//   Instantiated by onehot_mux_sel only when ONEHOT_MUX_SEL_CHECK_EN is defined.
module onehot_mux_sel_check
  import onehot_mux_pkg::*;
#(
  parameter int N_INPUTS = ONEHOT_MUX_DEF_N_INPUTS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] sel,
  output logic                sel_none,
  output logic                sel_multi,
  output logic                sel_err
);

  localparam int DEPTH  = onehot_mux_tree_depth(N_INPUTS);
  localparam int LEAVES = 1 << DEPTH;

  // Balanced tree of (any, two) pairs. A node has two-or-more set when either
  // child already has two-or-more, or both children have at least one.
  // Level 0 is the root, level DEPTH holds the leaves; unused leaves are zero.
  for (genvar d = 0; d <= DEPTH; d++) begin : g_lvl
    logic any_n [1 << d];
    logic two_n [1 << d];
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      if (d == DEPTH) begin : g_leaf
        if (j < N_INPUTS) begin : g_used
          assign any_n[j] = sel[j];
        end else begin : g_pad
          assign any_n[j] = 1'b0;
        end
        assign two_n[j] = 1'b0;
      end else begin : g_inner
        assign any_n[j] = g_lvl[d+1].any_n[2*j] | g_lvl[d+1].any_n[2*j+1];
        assign two_n[j] = g_lvl[d+1].two_n[2*j] | g_lvl[d+1].two_n[2*j+1] |
                          (g_lvl[d+1].any_n[2*j] & g_lvl[d+1].any_n[2*j+1]);
      end
    end
  end

  assign sel_none  = ~g_lvl[0].any_n[0];
  assign sel_multi = g_lvl[0].two_n[0];

  // Sticky error: once set, only reset clears it.
  logic sel_err_d;
  logic sel_err_q;

  always_comb begin
    sel_err_d = sel_err_q | sel_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  // LEAVES is used only through DEPTH; keep it for readability of the tree.
  logic unused_leaves;
  assign unused_leaves = (LEAVES == 0);

endmodule

// File: rtl/onehot_mux_sel.sv
// onehot_mux_sel
//   AND-OR multiplexer selecting one of N_INPUTS slices of W_INPUT bits with a
//   one-hot select. All-zero select gives all-zero data; multi-hot select gives
//   the OR of the selected slices (no priority). Used e.g. to steer HRDATA back
//   through an AHB-lite splitter using the data-phase slave-select vector.
//   Ports:
//     clk, rst_n : clock / asynchronous active-low reset, monitor only
//     in         : N_INPUTS*W_INPUT packed slices, slice i = in[i*W_INPUT +: W_INPUT]
//     sel        : one-hot select, bit i selects slice i
//     out        : selected data (combinational)
//     sel_none   : combinational, sel is all zero
//     sel_multi  : combinational, two or more sel bits set
//     sel_err    : registered sticky multi-hot flag
//   Configuration macro ONEHOT_MUX_SEL_CHECK_EN:
//     defined   - sel_multi / sel_err come from onehot_mux_sel_check
//     undefined - sel_multi / sel_err are tied to 0, no flops, clk/rst_n unused
module onehot_mux_sel
  import onehot_mux_pkg::*;
#(
  parameter int N_INPUTS = ONEHOT_MUX_DEF_N_INPUTS,
  parameter int W_INPUT  = ONEHOT_MUX_DEF_W_INPUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_INPUTS*W_INPUT-1:0]  in,
  input  logic [N_INPUTS-1:0]          sel,
  output logic [W_INPUT-1:0]           out,
  output logic                         sel_none,
  output logic                         sel_multi,
  output logic                         sel_err
);

  localparam int DEPTH = onehot_mux_tree_depth(N_INPUTS);

  // Gated slices at the leaves, then a balanced OR tree toward the root.
  // Each level is its own array so the tree has no self-referencing signal.
  for (genvar d = 0; d <= DEPTH; d++) begin : g_lvl
    logic [W_INPUT-1:0] node [1 << d];
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      if (d == DEPTH) begin : g_leaf
        if (j < N_INPUTS) begin : g_used
          assign node[j] = in[j*W_INPUT +: W_INPUT] & {W_INPUT{sel[j]}};
        end else begin : g_pad
          assign node[j] = '0;
        end
      end else begin : g_inner
        assign node[j] = g_lvl[d+1].node[2*j] | g_lvl[d+1].node[2*j+1];
      end
    end
  end

  assign out = g_lvl[0].node[0];

`ifdef ONEHOT_MUX_SEL_CHECK_EN
  onehot_mux_sel_check #(
    .N_INPUTS (N_INPUTS)
  ) u_check (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .sel_none  (sel_none),
    .sel_multi (sel_multi),
    .sel_err   (sel_err)
  );
`else
  assign sel_none  = ~|sel;
  assign sel_multi = 1'b0;
  assign sel_err   = 1'b0;

  // Clock and reset have no load when the monitor is compiled out.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};
`endif

endmodule

// File: tb/tb_onehot_mux_sel.sv
// tb_onehot_mux_sel
//   Bench for onehot_mux_sel with N_INPUTS=3, W_INPUT=32. Expectations follow
//   the build: with ONEHOT_MUX_SEL_CHECK_EN the multi-hot flags are live,
//   otherwise they must read 0.
module tb_onehot_mux_sel;

  localparam int N = 3;
  localparam int W = 32;

`ifdef ONEHOT_MUX_SEL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in;
  logic [N-1:0]   sel;
  logic [W-1:0]   out;
  logic           sel_none;
  logic           sel_multi;
  logic           sel_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  onehot_mux_sel #(
    .N_INPUTS (N),
    .W_INPUT  (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .sel       (sel),
    .out       (out),
    .sel_none  (sel_none),
    .sel_multi (sel_multi),
    .sel_err   (sel_err)
  );

  // ---------------- reference model ----------------
  int checks;
  int errors;
  bit model_err;
  logic [W-1:0] exp_q[$];

  function automatic int count_set(input logic [N-1:0] s);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (s[i]) c = c + 1;
    return c;
  endfunction

  function automatic logic [W-1:0] ref_out(input logic [N*W-1:0] d, input logic [N-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (s[i]) r = r | d[i*W +: W];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Advances one clock edge (letting sel_err capture the current inputs), then
  // drives new inputs and checks every output against the model.
  task automatic apply(input logic [N-1:0] s, input logic [N*W-1:0] d, input string tag);
    bit multi_now;
    logic [W-1:0] e;
    multi_now = (count_set(sel) >= 2);
    @(posedge clk);
    if (rst_n && CHECK_EN && multi_now) model_err = 1'b1;
    #1;
    sel = s;
    in  = d;
    exp_q.push_back(ref_out(d, s));
    #1;
    e = exp_q.pop_front();
    chk({tag, ".out"},       {32'd0, out},       {32'd0, e});
    chk({tag, ".sel_none"},  {63'd0, sel_none},  {63'd0, (count_set(s) == 0)});
    chk({tag, ".sel_multi"}, {63'd0, sel_multi}, {63'd0, (CHECK_EN && count_set(s) >= 2)});
    chk({tag, ".sel_err"},   {63'd0, sel_err},   {63'd0, model_err});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0] sel;
    logic [W-1:0] exp_out;
    bit           exp_none;
    bit           exp_multi;
  } vec_t;

  localparam logic [N*W-1:0] IN3 = {32'hCCCC0000, 32'h0000BBBB, 32'hAAAA0000};

  vec_t tbl [8];

  initial begin
    checks    = 0;
    errors    = 0;
    model_err = 1'b0;

    tbl[0] = '{3'b001, 32'hAAAA0000, 1'b0, 1'b0};
    tbl[1] = '{3'b010, 32'h0000BBBB, 1'b0, 1'b0};
    tbl[2] = '{3'b100, 32'hCCCC0000, 1'b0, 1'b0};
    tbl[3] = '{3'b000, 32'h00000000, 1'b1, 1'b0};
    tbl[4] = '{3'b011, 32'hAAAABBBB, 1'b0, 1'b1};
    tbl[5] = '{3'b001, 32'hAAAA0000, 1'b0, 1'b0};
    tbl[6] = '{3'b110, 32'hCCCCBBBB, 1'b0, 1'b1};
    tbl[7] = '{3'b111, 32'hEEEEBBBB, 1'b0, 1'b1};

    // reset state
    rst_n = 1'b0;
    sel   = '0;
    in    = IN3;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.sel_err",  {63'd0, sel_err},  64'd0);
    chk("reset.sel_none", {63'd0, sel_none}, 64'd1);
    chk("reset.out",      {32'd0, out},      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: one-hot, zero, multi-hot, return to one-hot; sel_err must stay 0
    // through the first four rows and stick at 1 after the 3'b011 row when live
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      if (CHECK_EN && count_set(sel) >= 2) model_err = 1'b1;
      #1;
      sel = tbl[i].sel;
      in  = IN3;
      #1;
      chk($sformatf("tbl%0d.out", i),       {32'd0, out},       {32'd0, tbl[i].exp_out});
      chk($sformatf("tbl%0d.sel_none", i),  {63'd0, sel_none},  {63'd0, tbl[i].exp_none});
      chk($sformatf("tbl%0d.sel_multi", i), {63'd0, sel_multi}, {63'd0, (CHECK_EN & tbl[i].exp_multi)});
      chk($sformatf("tbl%0d.sel_err", i),   {63'd0, sel_err},   {63'd0, model_err});
    end

    // sel_err latency: first multi-hot cycle reads 0, next edge reads 1
    rst_n = 1'b0;
    model_err = 1'b0;
    sel = 3'b001;
    #1;
    rst_n = 1'b1;
    apply(3'b101, IN3, "lat0");
    chk("lat0.err_clear", {63'd0, sel_err}, 64'd0);
    apply(3'b010, IN3, "lat1");
    chk("lat1.err_set", {63'd0, sel_err}, {63'd0, CHECK_EN});

    // async reset between edges clears sel_err without a clock
    #1;
    rst_n = 1'b0;
    #1;
    model_err = 1'b0;
    chk("async_rst.sel_err", {63'd0, sel_err}, 64'd0);
    #1;
    rst_n = 1'b1;
    apply(3'b111, IN3, "rst_then_111");
    apply(3'b001, IN3, "after_111");
    chk("after_111.err", {63'd0, sel_err}, {63'd0, CHECK_EN});

    // multi-hot present in the same cycle reset deasserts
    #1;
    rst_n = 1'b0;
    sel   = 3'b110;
    #1;
    model_err = 1'b0;
    chk("rst_multi.sel_err", {63'd0, sel_err}, 64'd0);
    chk("rst_multi.out", {32'd0, out}, 64'h00000000CCCCBBBB);
    rst_n = 1'b1;
    apply(3'b100, IN3, "rst_release");

    // randomized stimulus against the model
    rst_n = 1'b0;
    model_err = 1'b0;
    sel = '0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0]   rs;
      logic [N*W-1:0] rd;
      rs = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) != 0) rs = N'(1 << $urandom_range(0, N - 1));
      rd = {$urandom, $urandom, $urandom};
      apply(rs, rd, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/onehot_mux_sel.md
# onehot_mux_sel

Combinational AND-OR multiplexer that selects one of N equal-width input slices with a one-hot select vector, plus a registered select-integrity monitor. It sits in the AHB-lite bus fabric, for example in the splitter read-data return path, where the data-phase slave-select vector steers HRDATA back to the master. An all-zero select yields an all-zero output, so idle or decode-error data phases return zeros.

## Interface
Parameters:
- N_INPUTS, default 2, number of input slices (≥1).
- W_INPUT, default 32, width of each slice and of out (≥1).

Ports:
- clk  in  1  clock; used only by the integrity monitor.
- rst_n  in  1  reset, asynchronous, active-low.
- in  in  N_INPUTS*W_INPUT  packed inputs; slice i is in[i*W_INPUT +: W_INPUT].
- sel  in  N_INPUTS  one-hot select; bit i selects slice i.
- out  out  W_INPUT  selected data.
- sel_none  out  1  combinational; 1 when sel is all zero.
- sel_multi  out  1  combinational; 1 when more than one sel bit is set.
- sel_err  out  1  registered sticky flag; set by any cycle with sel_multi=1.

## Operation
- out is the bitwise OR over i of (slice i AND {W_INPUT{sel[i]}}). There is no priority logic.
- When sel is one-hot, out equals the selected slice.
- When sel is zero, out is 0.
- When sel is multi-hot, out is the bitwise OR of all selected slices. This is defined behaviour; it is never X and never a priority pick.
- sel_none is the NOR of sel.
- sel_multi is 1 when popcount(sel) ≥ 2. It is computed from a pairwise "any-set"/"two-or-more-set" reduction tree and needs no adder.
- sel_err:
  - Cleared by reset.
  - Set on the clk rising edge when sel_multi=1.
  - Holds at 1 until the next reset; no other clear path exists.
- When N_INPUTS=1: out = in & {W_INPUT{sel[0]}}, and sel_multi is constant 0.

## Timing
- in/sel → out, sel_none and sel_multi are purely combinational, with zero-cycle latency. There are no internal registers in this path.
- sel_err goes high one clk edge after the first cycle in which sel_multi=1.
- sel_err reset value is 0. Assertion of rst_n clears it asynchronously, even in the middle of an error cycle.
- If sel is multi-hot in the same cycle that rst_n deasserts, sel_err sets on the next rising edge.
- out, sel_none and sel_multi have no reset value; they follow their inputs during reset.
- There is no handshake; out is valid whenever the inputs are stable.

## Configuration
- Macro: ONEHOT_MUX_SEL_CHECK_EN.
- Defined: sel_multi and sel_err are implemented as described above.
- Undefined:
  - sel_multi and sel_err are tied to constant 0.
  - No flip-flops are instantiated, and clk/rst_n are unused.
  - out and sel_none are unchanged.

## Structure
- Shared package onehot_mux_pkg holds the default width constants (ONEHOT_MUX_DEF_N_INPUTS=2 and ONEHOT_MUX_DEF_W_INPUT=32) and a function giving the reduction-tree depth (ceil log2 of N_INPUTS).
- The top level contains the AND-OR datapath, built as a generate loop of gated slices followed by a balanced OR tree.
- Sub-module onehot_mux_sel_check contains the popcount-≥2 tree, sel_none and the sticky sel_err register. It is instantiated only under ONEHOT_MUX_SEL_CHECK_EN.

## Test plan
All scenarios use N_INPUTS=3 and W_INPUT=32, with in = {32'hCCCC0000, 32'h0000BBBB, 32'hAAAA0000} (slice 2, slice 1, slice 0). Scenarios 3 and 4 require ONEHOT_MUX_SEL_CHECK_EN defined.
1. sel=3'b001, then 3'b010, then 3'b100 → out = AAAA0000, then 0000BBBB, then CCCC0000 in the same cycle each time; sel_none=0, sel_multi=0, sel_err stays 0.
2. sel=3'b000 → out=0, sel_none=1, sel_multi=0.
3. sel=3'b011 for one cycle, then 3'b001 → out=AAAABBBB and sel_multi=1 during that cycle; sel_err=1 from the next edge and remains 1 after sel returns one-hot.
4. sel_err=1, then rst_n pulsed low between edges → sel_err drops to 0 immediately without a clock edge. Repeat with sel=3'b111 → out=EEEEBBBB and sel_err sets on the next edge.
5. ONEHOT_MUX_SEL_CHECK_EN undefined, sel=3'b110 → out=CCCCBBBB, sel_multi=0, sel_err=0.
